cordic_fix2float_pipe: RTL and testbench

- Pipelined fixed-to-float converter sitting directly downstream of the CORDIC stage chain.
- Consumes the 22-bit signed Q2.20 x result (cosine) and produces the IEEE-754 single-precision word returned to the custom-instruction result path.
- Replaces the combinational fixed-to-float conversion with a 3-stage registered pipeline and valid/ready flow control, so the CORDIC pipeline can be back-pressured.

---
 rtl/cordic_pkg.sv | 17 +
 rtl/cordic_lzc.sv | 26 ++
 rtl/cordic_fix2float_pipe.sv | 136 +++++++++++++
 tb/tb_cordic_fix2float_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC types and constants: datapath width, fixed-point format and the
// IEEE-754 single-precision field layout.
package cordic_pkg;

    localparam int CORDIC_WIDTH     = 22;
    localparam int CORDIC_FRAC_BITS = 20;
    localparam int FP32_BIAS        = 127;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    typedef logic signed [21:0] fix_t;

endpackage

// File: rtl/cordic_lzc.sv
// Leading-one detector: returns the bit index of the most significant set bit of
// vec, plus a flag for the all-zero vector (index reads 0 in that case).
module cordic_lzc
    import cordic_pkg::*;
#(
    parameter int WIDTH = CORDIC_WIDTH
) (
    input  logic [WIDTH-1:0] vec,
    output logic [4:0]       pos,
    output logic             all_zero
);

    // NOTE: defaults assigned first so no path leaves pos/all_zero unassigned (no latch).
    always_comb begin
        pos      = '0;
        all_zero = 1'b1;
        // Scan upwards; the last set bit seen is the leading one.
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                pos      = 5'(i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cordic_fix2float_pipe.sv
// Three-stage pipelined Q2.20 -> IEEE-754 single converter with valid/ready flow
// control. Optional conversion counter enabled by CORDIC_F2F_STATS_EN.
module cordic_fix2float_pipe
    import cordic_pkg::*;
#(
    parameter int WIDTH     = CORDIC_WIDTH,
    parameter int FRAC_BITS = CORDIC_FRAC_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_fixed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_float
`ifdef CORDIC_F2F_STATS_EN
    ,
    output logic [15:0]      conv_count
`endif
);

    localparam int          SHW        = WIDTH + 24;
    localparam logic [7:0]  EXP_OFFSET = 8'(FP32_BIAS - FRAC_BITS);

    // Stage 1: sign / magnitude
    logic             s1_valid;
    logic             s1_sign;
    logic             s1_zero;
    logic [WIDTH-1:0] s1_mag;

    // Stage 2: normalised fields
    logic             s2_valid;
    logic             s2_sign;
    logic             s2_zero;
    logic [7:0]       s2_exp;
    logic [22:0]      s2_mant;

    logic             s1_en;
    logic             s2_en;
    logic             s3_en;

    logic [WIDTH-1:0] abs_in;
    logic [4:0]       lzc_pos;
    logic             lzc_zero;
    logic [SHW-1:0]   norm_wide;
    fp32_t            packed_word;

    // Each stage may load when empty or when its successor is loading, so bubbles collapse.
    always_comb begin
        s3_en = !out_valid || out_ready;
        s2_en = !s2_valid  || s3_en;
        s1_en = !s1_valid  || s2_en;
    end

    assign in_ready = !s1_valid || s1_en;

    // Two's complement negate; the most negative input maps to its own bit pattern,
    // which read as unsigned is exactly the magnitude.
    always_comb begin
        abs_in = in_fixed[WIDTH-1] ? (~in_fixed + WIDTH'(1)) : in_fixed;
    end

    cordic_lzc #(
        .WIDTH (WIDTH)
    ) u_lzc (
        .vec      (s1_mag),
        .pos      (lzc_pos),
        .all_zero (lzc_zero)
    );

    // Move the leading one to bit 23; bits 22..0 are the stored mantissa.
    always_comb begin
        norm_wide = SHW'(s1_mag) << (5'd23 - lzc_pos);
    end

    always_comb begin
        packed_word.sign = s2_sign;
        packed_word.exp  = s2_exp;
        packed_word.mant = s2_mant;
        if (s2_zero) begin
            packed_word = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; mixing in blocking
    // assignments here would make stage-to-stage transfer order-dependent.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_float <= 32'h0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
            end
            if (s3_en) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_float <= packed_word;
                end
            end
        end
    end

    // NOTE: payload registers are not reset; they are only observed behind their
    // valid bits, which are.
    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            s1_sign <= in_fixed[WIDTH-1];
            s1_zero <= (in_fixed == '0);
            s1_mag  <= abs_in;
        end
        if (s2_en && s1_valid) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero || lzc_zero;
            s2_exp  <= EXP_OFFSET + 8'(lzc_pos);
            s2_mant <= norm_wide[22:0];
        end
    end

`ifdef CORDIC_F2F_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conv_count <= 16'h0;
        end else if (out_valid && out_ready && (conv_count != 16'hFFFF)) begin
            conv_count <= conv_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cordic_fix2float_pipe.sv
// Scoreboard bench for cordic_fix2float_pipe: directed vectors with hand-computed
// IEEE-754 results, latency, back-pressure, mid-stream reset and optional counter.
module tb_cordic_fix2float_pipe;
    import cordic_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] in_fixed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
`ifdef CORDIC_F2F_STATS_EN
    logic [15:0] conv_count;
`endif

    cordic_fix2float_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fixed  (in_fixed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float)
`ifdef CORDIC_F2F_STATS_EN
        ,
        .conv_count (conv_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [21:0] din;
        logic [31:0] exp;
        int          cyc_in;
        int          lat;
    } item_t;

    item_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    xfer_count = 0;

    // Hand-computed pairs; first seven are the single-sample and boundary cases.
    logic [21:0] vin [13] = '{22'h100000, 22'h09B74E, 22'h300000, 22'h200000,
                              22'h1FFFFF, 22'h000001, 22'h000000, 22'h040000,
                              22'h3C0000, 22'h180000, 22'h280000, 22'h000003,
                              22'h3FFFFF};
    logic [31:0] vout[13] = '{32'h3F800000, 32'h3F1B74E0, 32'hBF800000, 32'hC0000000,
                              32'h3FFFFFF8, 32'h35800000, 32'h00000000, 32'h3E800000,
                              32'hBE800000, 32'h3FC00000, 32'hBFC00000, 32'h36400000,
                              32'hB5800000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on every output transfer and checks values, latency and hold-stability.
    logic        held = 1'b0;
    logic [31:0] held_val = '0;
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_float, held_val);
            end
            if (out_valid && out_ready && !reset) begin
                xfer_count++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %08h expected none (cycle %0d)", out_float, cyc);
                end else begin
                    it = sb.pop_front();
                    check($sformatf("data_%06h", it.din), out_float, it.exp);
                    if (it.lat != 0) begin
                        check($sformatf("latency_%06h", it.din), 32'(cyc - it.cyc_in), 32'(it.lat));
                    end
                end
            end
            held     = !reset && out_valid && !out_ready;
            held_val = out_float;
        end
    end

    // Presents one sample from posedge+1 until accepted; waits reports stalled cycles.
    task automatic put(input logic [21:0] d, input logic [31:0] e, input int lat, output int waits);
        item_t it;
        logic  done;
        waits    = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        in_fixed = d;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                it.din    = d;
                it.exp    = e;
                it.cyc_in = cyc;
                it.lat    = lat;
                sb.push_back(it);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waits;
        int stall_acc;
        int idx;
        logic saw_block;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_fixed  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_float", out_float, 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef CORDIC_F2F_STATS_EN
        check("reset_conv_count", 32'(conv_count), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Single samples with 3-cycle latency, including the boundary values.
        for (int i = 0; i < 7; i++) begin
            put(vin[i], vout[i], 3, waits);
            idle(5);
        end
        drain();

        // Back-to-back stream: in_ready must never drop.
        for (int i = 0; i < 8; i++) begin
            put(vin[(i + 5) % 13], vout[(i + 5) % 13], 3, waits);
            check("stream_in_ready", 32'(waits), 32'd0);
        end
        drain();

        // Back-pressure: out_ready low for 5 cycles mid-stream.
        idx       = 0;
        stall_acc = 0;
        saw_block = 1'b0;
        for (int c = 0; c < 80 && idx < 16; c++) begin
            item_t it;
            out_ready = !(c >= 4 && c < 9);
            in_valid  = 1'b1;
            in_fixed  = vin[idx % 13];
            @(negedge clk);
            if (!out_ready) begin
                if (in_ready) stall_acc++;
                else saw_block = 1'b1;
            end
            if (in_ready) begin
                it.din    = vin[idx % 13];
                it.exp    = vout[idx % 13];
                it.cyc_in = cyc;
                it.lat    = 0;
                sb.push_back(it);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_accepts_le3", 32'(stall_acc <= 3), 32'd1);
        check("bp_in_ready_low", 32'(saw_block), 32'd1);
        drain();
`ifdef CORDIC_F2F_STATS_EN
        check("stats_count", 32'(conv_count), 32'(xfer_count));
`endif

        // Mid-operation reset with three samples stalled in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) put(vin[i + 7], vout[i + 7], 0, waits);
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        xfer_count = 0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef CORDIC_F2F_STATS_EN
        check("midrst_conv_count", 32'(conv_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(6);
        put(22'h100000, 32'h3F800000, 3, waits);
        drain();

        // Ten more transfers for the counter, then a final stream check.
        for (int i = 0; i < 10; i++) put(vin[i], vout[i], 3, waits);
        drain();
`ifdef CORDIC_F2F_STATS_EN
        check("stats_after_11", 32'(conv_count), 32'd11);
`endif
        check("xfer_after_reset", 32'(xfer_count), 32'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
